// File: rtl/ram_4002_responder.sv
// ============================================================================
// Module   : ram_4002_responder
// Brief    : 4002-style data RAM and output port that responds on the MCS-4 nibble bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_4002_responder #(
  parameter logic [1:0] CHIP_ID = 2'd0
) (
  input  logic       sysclk,
  input  logic       poc_n,
  input  logic       clk1,
  input  logic       clk2,
  input  logic       sync,
  input  logic       cm_ram,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  output logic [3:0] port_out
);

  typedef enum logic [3:0] {
    PH_UNSYNC = 4'd0,
    PH_A1     = 4'd1,
    PH_A2     = 4'd2,
    PH_A3     = 4'd3,
    PH_M1     = 4'd4,
    PH_M2     = 4'd5,
    PH_X1     = 4'd6,
    PH_X2     = 4'd7,
    PH_X3     = 4'd8
  } phase_t;

  phase_t     phase_q, phase_d;
  logic       clk1_prev_q, clk1_prev_d;
  logic       clk2_prev_q, clk2_prev_d;
  logic       sync_seen_q, sync_seen_d;
  logic [3:0] bus_q, bus_d;
  logic       sel_q, sel_d;
  logic [1:0] reg_addr_q, reg_addr_d;
  logic [3:0] char_addr_q, char_addr_d;
  logic       src_q, src_d;
  logic       io_pend_q, io_pend_d;
  logic [3:0] opa_q, opa_d;
  logic       data_oe_q, data_oe_d;
  logic [3:0] data_out_q, data_out_d;
  logic [3:0] port_out_q, port_out_d;
  logic [3:0] main_q [64];
  logic [3:0] main_d [64];
  logic [3:0] stat_q [16];
  logic [3:0] stat_d [16];

  logic       clk1_rise;
  logic       clk2_fall;
  logic       resync;
  logic       synced;
  logic       op_is_read;
  logic [3:0] rd_val;

  assign clk1_rise = clk1 & ~clk1_prev_q;
  assign clk2_fall = ~clk2 & clk2_prev_q;
  assign resync    = clk1_rise & (sync_seen_q | sync);
  assign synced    = (phase_q != PH_UNSYNC);

  // SBM/RDM/ADM read the addressed main char, RD0..RD3 read a status char.
  assign op_is_read = (opa_q == 4'b1000) || (opa_q == 4'b1001) ||
                      (opa_q == 4'b1011) || (opa_q[3:2] == 2'b11);
  assign rd_val     = (opa_q[3:2] == 2'b11) ? stat_q[{reg_addr_q, opa_q[1:0]}]
                                            : main_q[{reg_addr_q, char_addr_q}];

  always_comb begin
    phase_d     = phase_q;
    clk1_prev_d = clk1;
    clk2_prev_d = clk2;
    sync_seen_d = sync_seen_q;
    bus_d       = bus_q;
    sel_d       = sel_q;
    reg_addr_d  = reg_addr_q;
    char_addr_d = char_addr_q;
    src_d       = src_q;
    io_pend_d   = io_pend_q;
    opa_d       = opa_q;
    data_oe_d   = data_oe_q;
    data_out_d  = data_out_q;
    port_out_d  = port_out_q;
    main_d      = main_q;
    stat_d      = stat_q;

    if (clk1_rise) begin
      sync_seen_d = 1'b0;
    end else if (sync) begin
      sync_seen_d = 1'b1;
    end

    if (clk1_rise) begin
      if (resync) begin
        phase_d = PH_A1;
      end else begin
        case (phase_q)
          PH_UNSYNC: phase_d = PH_UNSYNC;
          PH_X3:     phase_d = PH_A1;
          default:   phase_d = phase_t'(phase_q + 4'd1);
        endcase
      end
    end

    if (synced && clk2) begin
      bus_d = data_in;
    end

    // Drive window opens on the edge into X2 and closes on the next clk1 edge.
    if (clk1_rise) begin
      data_oe_d = 1'b0;
      if ((phase_d == PH_X2) && io_pend_q && op_is_read) begin
        data_oe_d  = 1'b1;
        data_out_d = rd_val;
      end
      if ((phase_d == PH_X3) || resync) begin
        io_pend_d = 1'b0;
      end
      if (resync) begin
        src_d = 1'b0;
      end
    end

    if (clk2_fall && synced) begin
      case (phase_q)
        PH_M2: begin
          if (cm_ram) begin
            io_pend_d = sel_q;
            opa_d     = bus_q;
          end else begin
            io_pend_d = 1'b0;
          end
        end
        PH_X2: begin
          if (cm_ram) begin
            sel_d      = (bus_q[3:2] == CHIP_ID);
            reg_addr_d = bus_q[1:0];
            src_d      = 1'b1;
          end else begin
            src_d = 1'b0;
          end
          if (io_pend_q) begin
            if (opa_q == 4'b0000) begin
              main_d[{reg_addr_q, char_addr_q}] = bus_q;
            end else if (opa_q == 4'b0001) begin
              port_out_d = bus_q;
            end else if (opa_q[3:2] == 2'b01) begin
              stat_d[{reg_addr_q, opa_q[1:0]}] = bus_q;
            end
          end
        end
        PH_X3: begin
          if (cm_ram && src_q && sel_q) begin
            char_addr_d = bus_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    clk1_prev_q <= clk1_prev_d;
    clk2_prev_q <= clk2_prev_d;
    if (!poc_n) begin
      phase_q     <= PH_UNSYNC;
      sync_seen_q <= 1'b0;
      bus_q       <= 4'h0;
      sel_q       <= 1'b0;
      reg_addr_q  <= 2'd0;
      char_addr_q <= 4'h0;
      src_q       <= 1'b0;
      io_pend_q   <= 1'b0;
      opa_q       <= 4'h0;
      data_oe_q   <= 1'b0;
      data_out_q  <= 4'h0;
      port_out_q  <= 4'h0;
      main_q      <= '{default: 4'h0};
      stat_q      <= '{default: 4'h0};
    end else begin
      phase_q     <= phase_d;
      sync_seen_q <= sync_seen_d;
      bus_q       <= bus_d;
      sel_q       <= sel_d;
      reg_addr_q  <= reg_addr_d;
      char_addr_q <= char_addr_d;
      src_q       <= src_d;
      io_pend_q   <= io_pend_d;
      opa_q       <= opa_d;
      data_oe_q   <= data_oe_d;
      data_out_q  <= data_out_d;
      port_out_q  <= port_out_d;
      main_q      <= main_d;
      stat_q      <= stat_d;
    end
  end

  assign data_oe  = data_oe_q;
  assign data_out = data_out_q;
  assign port_out = port_out_q;

endmodule

`default_nettype wire
